// File: rtl/hrm_cu_pkg.sv
// hrm_cu_pkg: state encodings, opcodes and datapath select codes
// shared by the HRM control sequencer and its strobe decoder.
package hrm_cu_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH_I    = 5'd1,
        S_WAIT_KEY   = 5'd2,
        S_LOAD_IR    = 5'd3,
        S_DECODE     = 5'd4,
        S_INBOX      = 5'd5,
        S_OUTBOX     = 5'd6,
        S_INC_PC     = 5'd7,
        S_INC_PC2    = 5'd8,
        S_FETCH_O    = 5'd9,
        S_JUMP       = 5'd10,
        S_JUMPZ      = 5'd11,
        S_JUMPN      = 5'd12,
        S_SET        = 5'd13,
        S_INIT_TIMER = 5'd14,
        S_WAIT_TIMER = 5'd15,
        S_LOAD_AR    = 5'd16,
        S_READMEM    = 5'd17,
        S_READMEM2   = 5'd18,
        S_LOAD_AR2   = 5'd19,
        S_COPYTO     = 5'd20,
        S_COPYFROM   = 5'd21,
        S_ADD        = 5'd22,
        S_SUB        = 5'd23,
        S_BUMPP      = 5'd24,
        S_BUMPN      = 5'd25,
        S_HALT       = 5'd26
    } state_t;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPP    = 4'h6;
    localparam logic [3:0] OP_BUMPN    = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_SET      = 4'hB;
    localparam logic [3:0] OP_WAIT     = 4'hC;
    localparam logic [3:0] OP_NOP1     = 4'hD;
    localparam logic [3:0] OP_NOP2     = 4'hE;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [1:0] MUXR_IN  = 2'b00;
    localparam logic [1:0] MUXR_MEM = 2'b01;
    localparam logic [1:0] MUXR_IMM = 2'b10;
    localparam logic [1:0] MUXR_ALU = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;
    localparam logic [2:0] ALU_NEG = 3'b100;

endpackage

// File: rtl/hrm_cu_outdec.sv
// hrm_cu_outdec: Moore strobe decoder, maps the sequencer state
// to one-cycle datapath strobes and R/ALU select codes.
module hrm_cu_outdec
    import hrm_cu_pkg::*;
(
    input  state_t     state,
    output logic       wIR,
    output logic       wR,
    output logic       srcA,
    output logic       wM,
    output logic       wAR,
    output logic       wPC,
    output logic       rIn,
    output logic       wO,
    output logic       ijump,
    output logic       branch,
    output logic       rst,
    output logic       halt,
    output logic       enT,
    output logic [1:0] muxR,
    output logic [2:0] aluCtl
);

    always_comb begin
        wIR    = 1'b0;
        wR     = 1'b0;
        srcA   = 1'b0;
        wM     = 1'b0;
        wAR    = 1'b0;
        wPC    = 1'b0;
        rIn    = 1'b0;
        wO     = 1'b0;
        ijump  = 1'b0;
        branch = 1'b0;
        rst    = 1'b0;
        halt   = 1'b0;
        enT    = 1'b0;
        muxR   = MUXR_IN;
        aluCtl = ALU_ADD;
        case (state)
            S_RESET:      rst = 1'b1;
            S_LOAD_IR:    wIR = 1'b1;
            S_INBOX: begin
                rIn  = 1'b1;
                wR   = 1'b1;
                muxR = MUXR_IN;
            end
            S_OUTBOX:     wO = 1'b1;
            S_COPYFROM: begin
                wR   = 1'b1;
                muxR = MUXR_MEM;
            end
            S_SET: begin
                wR   = 1'b1;
                muxR = MUXR_IMM;
            end
            S_ADD: begin
                wR     = 1'b1;
                muxR   = MUXR_ALU;
                aluCtl = ALU_ADD;
            end
            S_SUB: begin
                wR     = 1'b1;
                muxR   = MUXR_ALU;
                aluCtl = ALU_SUB;
            end
            S_BUMPP: begin
                wR     = 1'b1;
                muxR   = MUXR_ALU;
                aluCtl = ALU_INC;
            end
            S_BUMPN: begin
                wR     = 1'b1;
                muxR   = MUXR_ALU;
                aluCtl = ALU_DEC;
            end
            S_COPYTO:     wM = 1'b1;
            S_LOAD_AR:    wAR = 1'b1;
            S_LOAD_AR2: begin
                wAR  = 1'b1;
                srcA = 1'b1;
            end
            S_INC_PC,
            S_INC_PC2:    wPC = 1'b1;
            S_JUMP: begin
                wPC    = 1'b1;
                branch = 1'b1;
                ijump  = 1'b1;
            end
            S_JUMPZ: begin
                wPC    = 1'b1;
                branch = 1'b1;
                aluCtl = ALU_ADD;
            end
            S_JUMPN: begin
                wPC    = 1'b1;
                branch = 1'b1;
                aluCtl = ALU_NEG;
            end
            S_INIT_TIMER: enT = 1'b1;
            S_HALT:       halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/hrm_ctrl_seq.sv
// hrm_ctrl_seq: HRM CPU control sequencer with NCH I/O channels.
// Build option HRM_CU_STEP_EN adds the single-step WAIT_KEY state.
module hrm_ctrl_seq
    import hrm_cu_pkg::*;
#(
    parameter  int NCH = 2,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           i_rst,
    input  logic [7:0]     INSTR,
    input  logic [NCH-1:0] in_empty,
    input  logic [NCH-1:0] out_full,
    input  logic           mem_ack,
    input  logic           busy,
    input  logic           debug,
    input  logic           nxt_instr,
    input  logic           resume,
    output logic           wIR,
    output logic           wR,
    output logic           srcA,
    output logic           wM,
    output logic           wAR,
    output logic           wPC,
    output logic           rIn,
    output logic           wO,
    output logic           ijump,
    output logic           branch,
    output logic           rst,
    output logic           halt,
    output logic           enT,
    output logic [1:0]     muxR,
    output logic [2:0]     aluCtl,
    output logic [CHW-1:0] ch_sel,
    output logic           fault
);

    localparam int NPAD = 1 << CHW;

    state_t           state;
    logic [3:0]       op;
    logic             ind;
    logic [CHW-1:0]   ch_idx;
    logic [NPAD-1:0]  empty_x;
    logic [NPAD-1:0]  full_x;
    logic             unused_bits;

    assign op  = INSTR[7:4];
    assign ind = INSTR[3];

    assign unused_bits = ^{INSTR, debug, nxt_instr};

    if (NCH > 1) begin : g_ch
        assign ch_idx = INSTR[CHW-1:0];
    end else begin : g_ch1
        assign ch_idx = '0;
    end

    // channels past NCH read as permanently empty/full so I/O stalls
    for (genvar i = 0; i < NPAD; i++) begin : g_pad
        if (i < NCH) begin : g_real
            assign empty_x[i] = in_empty[i];
            assign full_x[i]  = out_full[i];
        end else begin : g_none
            assign empty_x[i] = 1'b1;
            assign full_x[i]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state  <= S_RESET;
            ch_sel <= '0;
            fault  <= 1'b0;
        end else begin
            case (state)
                S_RESET:   state <= S_FETCH_I;
`ifdef HRM_CU_STEP_EN
                S_FETCH_I: state <= debug ? S_WAIT_KEY : S_LOAD_IR;
                S_WAIT_KEY: begin
                    if (nxt_instr)
                        state <= S_LOAD_IR;
                end
`else
                S_FETCH_I: state <= S_LOAD_IR;
`endif
                S_LOAD_IR: state <= S_DECODE;
                S_DECODE: begin
                    ch_sel <= ch_idx;
                    case (op)
                        OP_INBOX: begin
                            if (!empty_x[ch_idx])
                                state <= S_INBOX;
                        end
                        OP_OUTBOX: begin
                            if (!full_x[ch_idx])
                                state <= S_OUTBOX;
                        end
                        OP_HALT:  state <= S_HALT;
                        OP_NOP1,
                        OP_NOP2:  state <= S_INC_PC;
                        default:  state <= S_INC_PC2;
                    endcase
                end
                S_INC_PC:  state <= S_FETCH_I;
                S_INC_PC2: state <= S_FETCH_O;
                S_FETCH_O: begin
                    case (op)
                        OP_JUMP:  state <= S_JUMP;
                        OP_JUMPZ: state <= S_JUMPZ;
                        OP_JUMPN: state <= S_JUMPN;
                        OP_SET:   state <= S_SET;
                        OP_WAIT:  state <= S_INIT_TIMER;
                        default:  state <= S_LOAD_AR;
                    endcase
                end
                S_LOAD_AR: begin
                    if (ind)
                        state <= S_READMEM2;
                    else if (op == OP_COPYTO)
                        state <= S_COPYTO;
                    else
                        state <= S_READMEM;
                end
                S_READMEM2: begin
                    if (mem_ack)
                        state <= S_LOAD_AR2;
                end
                S_LOAD_AR2: begin
                    if (op == OP_COPYTO)
                        state <= S_COPYTO;
                    else
                        state <= S_READMEM;
                end
                S_READMEM: begin
                    if (mem_ack) begin
                        case (op)
                            OP_BUMPP:    state <= S_BUMPP;
                            OP_BUMPN:    state <= S_BUMPN;
                            OP_COPYFROM: state <= S_COPYFROM;
                            OP_ADD:      state <= S_ADD;
                            OP_SUB:      state <= S_SUB;
                            default: begin
                                state <= S_HALT;
                                fault <= 1'b1;
                            end
                        endcase
                    end
                end
                S_BUMPP,
                S_BUMPN:   state <= S_COPYTO;
                S_ADD,
                S_SUB,
                S_COPYFROM,
                S_COPYTO,
                S_SET,
                S_INBOX,
                S_OUTBOX:  state <= S_INC_PC;
                S_JUMP,
                S_JUMPZ,
                S_JUMPN:   state <= S_FETCH_I;
                S_INIT_TIMER: state <= S_WAIT_TIMER;
                S_WAIT_TIMER: begin
                    if (!busy)
                        state <= S_INC_PC;
                end
                S_HALT: begin
                    if (resume)
                        state <= S_INC_PC;
                end
                default: begin
                    state <= S_HALT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

    hrm_cu_outdec u_outdec (
        .state  (state),
        .wIR    (wIR),
        .wR     (wR),
        .srcA   (srcA),
        .wM     (wM),
        .wAR    (wAR),
        .wPC    (wPC),
        .rIn    (rIn),
        .wO     (wO),
        .ijump  (ijump),
        .branch (branch),
        .rst    (rst),
        .halt   (halt),
        .enT    (enT),
        .muxR   (muxR),
        .aluCtl (aluCtl)
    );

endmodule
